// File: rtl/pong_game_ctrl_if.sv
// Pong game controller bus.
// Groups the per-frame event inputs and the game-status outputs of
// pong_game_ctrl so the controller and the datapath/display share one
// bundle. Clock and reset stay outside as plain ports.
//   frame_tick  : one-cycle pulse at pixel (0,0) of each frame
//   start_btn   : synchronised, level-sensitive start button
//   hit / miss  : one-cycle paddle-bounce / ball-passed pulses
//   ball_run    : ball motion enable
//   ball_reset  : one-cycle ball recentre command
//   paddle_en   : paddle movement enable
//   speed       : ball speed level 0..3
//   score_bcd   : two BCD digits {tens, ones}
//   lives       : remaining lives
//   state       : IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4
//   blink       : display attention flag
interface pong_game_ctrl_if;
  logic       frame_tick;
  logic       start_btn;
  logic       hit;
  logic       miss;
  logic       ball_run;
  logic       ball_reset;
  logic       paddle_en;
  logic [1:0] speed;
  logic [7:0] score_bcd;
  logic [1:0] lives;
  logic [2:0] state;
  logic       blink;

  // Controller side.
  modport slave (
    input  frame_tick, start_btn, hit, miss,
    output ball_run, ball_reset, paddle_en, speed, score_bcd, lives, state, blink
  );

  // Datapath / stimulus side.
  modport master (
    output frame_tick, start_btn, hit, miss,
    input  ball_run, ball_reset, paddle_en, speed, score_bcd, lives, state, blink
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game controller.
// Sequences a game through IDLE -> SERVE -> PLAY -> MISS -> (SERVE | OVER),
// keeps score (BCD, saturating at 99), lives and speed level, and drives the
// ball/paddle enables. Every output is a flop updated one cycle after the
// input that causes it.
// Ports:
//   clk : rising-edge clock (pixel clock)
//   rst : synchronous active-high reset
//   bus : pong_game_ctrl_if.slave (frame/button/hit/miss in, status out)
module pong_game_ctrl #(
  parameter int SERVE_FRAMES   = 60,
  parameter int MISS_FRAMES    = 30,
  parameter int LIVES          = 3,
  parameter int HITS_PER_LEVEL = 4
) (
  input  logic             clk,
  input  logic             rst,
  pong_game_ctrl_if.slave  bus
);

  localparam int CNT_MAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int HIT_W   = $clog2(HITS_PER_LEVEL + 1);

  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] MISS_LOAD  = CNT_W'(MISS_FRAMES);
  localparam logic [HIT_W-1:0] HIT_LAST   = HIT_W'(HITS_PER_LEVEL - 1);
  localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    MISS  = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               start_prev_q, start_prev_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [HIT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [1:0]         speed_q, speed_d;
  logic [7:0]         score_q, score_d;
  logic [1:0]         lives_q, lives_d;
  logic               blink_q, blink_d;
  logic [3:0]         blink_cnt_q, blink_cnt_d;
  logic               ball_run_q, ball_run_d;
  logic               ball_reset_q, ball_reset_d;
  logic               paddle_en_q, paddle_en_d;
  logic               press;

  // Two-digit BCD increment, saturating at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign press = bus.start_btn & ~start_prev_q;

  always_comb begin
    state_d      = state_q;
    start_prev_d = bus.start_btn;
    frame_cnt_d  = frame_cnt_q;
    hit_cnt_d    = hit_cnt_q;
    speed_d      = speed_q;
    score_d      = score_q;
    lives_d      = lives_q;
    blink_d      = blink_q;
    blink_cnt_d  = blink_cnt_q;
    ball_reset_d = 1'b0;

    // Counters are loaded on the transition edge itself, so a frame_tick
    // arriving with the transition can never eat into the fresh count.
    case (state_q)
      IDLE, OVER: begin
        if (press) begin
          state_d      = SERVE;
          lives_d      = LIVES_INIT;
          score_d      = '0;
          speed_d      = '0;
          hit_cnt_d    = '0;
          frame_cnt_d  = SERVE_LOAD;
          ball_reset_d = 1'b1;
        end
      end
      SERVE: begin
        if (bus.frame_tick) begin
          if (frame_cnt_q <= CNT_W'(1)) begin
            frame_cnt_d = '0;
            state_d     = PLAY;
          end else begin
            frame_cnt_d = frame_cnt_q - CNT_W'(1);
          end
        end
      end
      PLAY: begin
        // miss wins over a coincident hit
        if (bus.miss) begin
          state_d     = MISS;
          lives_d     = lives_q - 2'd1;
          frame_cnt_d = MISS_LOAD;
        end else if (bus.hit) begin
          score_d = bcd_inc(score_q);
          if (hit_cnt_q == HIT_LAST) begin
            hit_cnt_d = '0;
            if (speed_q != 2'd3)
              speed_d = speed_q + 2'd1;
          end else begin
            hit_cnt_d = hit_cnt_q + HIT_W'(1);
          end
        end
      end
      MISS: begin
        if (bus.frame_tick) begin
          if (frame_cnt_q <= CNT_W'(1)) begin
            frame_cnt_d = '0;
            if (lives_q == 2'd0) begin
              state_d = OVER;
            end else begin
              state_d      = SERVE;
              frame_cnt_d  = SERVE_LOAD;
              speed_d      = '0;
              hit_cnt_d    = '0;
              ball_reset_d = 1'b1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Enables are registered versions of the next state.
    ball_run_d  = (state_d == PLAY);
    paddle_en_d = (state_d == SERVE) || (state_d == PLAY);

    // Blink phase runs continuously across MISS -> OVER and restarts
    // from 0 on every new entry into MISS.
    if ((state_d == MISS) || (state_d == OVER)) begin
      if (((state_q == MISS) || (state_q == OVER)) && bus.frame_tick) begin
        blink_cnt_d = blink_cnt_q + 4'd1;
        if (blink_cnt_q == 4'hF)
          blink_d = ~blink_q;
      end
    end else begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b1;
      frame_cnt_q  <= '0;
      hit_cnt_q    <= '0;
      speed_q      <= '0;
      score_q      <= '0;
      lives_q      <= LIVES_INIT;
      blink_q      <= 1'b0;
      blink_cnt_q  <= '0;
      ball_run_q   <= 1'b0;
      ball_reset_q <= 1'b0;
      paddle_en_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      frame_cnt_q  <= frame_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      speed_q      <= speed_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      blink_q      <= blink_d;
      blink_cnt_q  <= blink_cnt_d;
      ball_run_q   <= ball_run_d;
      ball_reset_q <= ball_reset_d;
      paddle_en_q  <= paddle_en_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.ball_run   = ball_run_q;
  assign bus.ball_reset = ball_reset_q;
  assign bus.paddle_en  = paddle_en_q;
  assign bus.speed      = speed_q;
  assign bus.score_bcd  = score_q;
  assign bus.lives      = lives_q;
  assign bus.blink      = blink_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Testbench for pong_game_ctrl: a hand-computed vector table, directed
// multi-cycle sequences, and a random phase, all shadowed cycle-by-cycle by
// a game-level reference model.
module tb_pong_game_ctrl;

  localparam int SERVE_F = 60;
  localparam int MISS_F  = 30;
  localparam int LIVES_N = 3;
  localparam int HPL     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pong_game_ctrl_if bus ();

  pong_game_ctrl #(
    .SERVE_FRAMES  (SERVE_F),
    .MISS_FRAMES   (MISS_F),
    .LIVES         (LIVES_N),
    .HITS_PER_LEVEL(HPL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: game-level quantities as plain integers.
  int m_mode   = 0;       // reported state code
  int m_frames = 0;       // frames left in the current hold
  int m_lives  = LIVES_N;
  int m_score  = 0;       // decimal score this game
  int m_hits   = 0;       // hits since the last serve (speed = hits / HPL)
  int m_att    = 0;       // frame ticks seen since entering MISS
  bit m_prev   = 1'b1;
  bit m_brst   = 1'b0;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void model_step(bit r, bit tick, bit start, bit hit, bit miss);
    bit pr;
    pr     = start && !m_prev;
    m_prev = start;
    m_brst = 1'b0;
    if (r) begin
      m_mode = 0; m_frames = 0; m_lives = LIVES_N; m_score = 0;
      m_hits = 0; m_att = 0; m_prev = 1'b1;
      return;
    end
    case (m_mode)
      0, 4: begin
        if (pr) begin
          m_mode = 1; m_lives = LIVES_N; m_score = 0; m_hits = 0;
          m_frames = SERVE_F; m_brst = 1'b1;
        end else if (m_mode == 4 && tick) begin
          m_att++;
        end
      end
      1: if (tick) begin
        m_frames--;
        if (m_frames == 0) m_mode = 2;
      end
      2: begin
        if (miss) begin
          m_mode = 3; m_lives--; m_frames = MISS_F; m_att = 0;
        end else if (hit) begin
          if (m_score < 99) m_score++;
          m_hits++;
        end
      end
      3: if (tick) begin
        m_att++;
        m_frames--;
        if (m_frames == 0) begin
          if (m_lives == 0) m_mode = 4;
          else begin
            m_mode = 1; m_frames = SERVE_F; m_hits = 0; m_brst = 1'b1;
          end
        end
      end
      default: m_mode = 0;
    endcase
  endfunction

  function automatic int model_vec();
    int v, spd, bl;
    spd = m_hits / HPL;
    if (spd > 3) spd = 3;
    bl = (m_mode == 3 || m_mode == 4) ? (m_att / 16) % 2 : 0;
    v = m_mode;
    v = (v << 1) | ((m_mode == 2) ? 1 : 0);
    v = (v << 1) | int'(m_brst);
    v = (v << 1) | ((m_mode == 1 || m_mode == 2) ? 1 : 0);
    v = (v << 2) | spd;
    v = (v << 8) | ((m_score / 10) * 16 + m_score % 10);
    v = (v << 2) | m_lives;
    v = (v << 1) | bl;
    return v;
  endfunction

  function automatic int dut_vec();
    int v;
    v = int'(bus.state);
    v = (v << 1) | int'(bus.ball_run);
    v = (v << 1) | int'(bus.ball_reset);
    v = (v << 1) | int'(bus.paddle_en);
    v = (v << 2) | int'(bus.speed);
    v = (v << 8) | int'(bus.score_bcd);
    v = (v << 2) | int'(bus.lives);
    v = (v << 1) | int'(bus.blink);
    return v;
  endfunction

  // One clock: drive inputs, advance the model with the edge, compare after it.
  task automatic step(bit r, bit tick, bit start, bit hit, bit miss);
    rst            = r;
    bus.frame_tick = tick;
    bus.start_btn  = start;
    bus.hit        = hit;
    bus.miss       = miss;
    @(posedge clk);
    model_step(r, tick, start, hit, miss);
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic ticks(int n);
    repeat (n) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    int n; int tick; int start; int hit; int miss;
    int st; int run; int brst; int pad; int spd; int score; int lives;
  } vec_t;

  vec_t vt[12];
  bit   r_start;

  initial begin
    //          n  tk st ht ms   st run brst pad spd score   lives
    vt[0]  = '{ 1, 0, 0, 0, 0,   0, 0,  0,   0,  0,  'h00,   3};
    vt[1]  = '{ 1, 0, 1, 0, 0,   1, 0,  1,   1,  0,  'h00,   3};
    vt[2]  = '{ 1, 0, 1, 0, 0,   1, 0,  0,   1,  0,  'h00,   3};
    vt[3]  = '{59, 1, 1, 0, 0,   1, 0,  0,   1,  0,  'h00,   3};
    vt[4]  = '{ 1, 1, 0, 0, 0,   2, 1,  0,   1,  0,  'h00,   3};
    vt[5]  = '{ 4, 0, 0, 1, 0,   2, 1,  0,   1,  1,  'h04,   3};
    vt[6]  = '{12, 0, 0, 1, 0,   2, 1,  0,   1,  3,  'h16,   3};
    vt[7]  = '{ 1, 0, 0, 1, 1,   3, 0,  0,   0,  3,  'h16,   2};
    vt[8]  = '{ 1, 0, 1, 0, 0,   3, 0,  0,   0,  3,  'h16,   2};
    vt[9]  = '{29, 1, 0, 0, 0,   3, 0,  0,   0,  3,  'h16,   2};
    vt[10] = '{ 1, 1, 0, 0, 0,   1, 0,  1,   1,  0,  'h16,   2};
    vt[11] = '{ 1, 0, 0, 0, 0,   1, 0,  0,   1,  0,  'h16,   2};

    bus.frame_tick = 1'b0;
    bus.start_btn  = 1'b0;
    bus.hit        = 1'b0;
    bus.miss       = 1'b0;

    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      repeat (vt[i].n)
        step(1'b0, vt[i].tick != 0, vt[i].start != 0, vt[i].hit != 0, vt[i].miss != 0);
      check($sformatf("vec%0d.state", i),  int'(bus.state),      vt[i].st);
      check($sformatf("vec%0d.run", i),    int'(bus.ball_run),   vt[i].run);
      check($sformatf("vec%0d.brst", i),   int'(bus.ball_reset), vt[i].brst);
      check($sformatf("vec%0d.paddle", i), int'(bus.paddle_en),  vt[i].pad);
      check($sformatf("vec%0d.speed", i),  int'(bus.speed),      vt[i].spd);
      check($sformatf("vec%0d.score", i),  int'(bus.score_bcd),  vt[i].score);
      check($sformatf("vec%0d.lives", i),  int'(bus.lives),      vt[i].lives);
    end

    // Score saturation: 16 + 83 = 99, one more hit stays at 99.
    ticks(SERVE_F);
    check("sat.state", int'(bus.state), 2);
    repeat (83) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("sat.score99", int'(bus.score_bcd), 'h99);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("sat.score_hold", int'(bus.score_bcd), 'h99);
    check("sat.speed", int'(bus.speed), 3);

    // Lose the remaining two lives, then watch blink in OVER.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("miss2.lives", int'(bus.lives), 1);
    ticks(MISS_F);
    check("miss2.state", int'(bus.state), 1);
    check("miss2.brst", int'(bus.ball_reset), 1);
    ticks(SERVE_F);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("miss3.lives", int'(bus.lives), 0);
    ticks(MISS_F - 1);
    check("miss3.hold", int'(bus.state), 3);
    ticks(1);
    check("over.state", int'(bus.state), 4);
    check("over.blink30", int'(bus.blink), 1);
    ticks(2);
    check("over.blink32", int'(bus.blink), 0);
    ticks(16);
    check("over.blink48", int'(bus.blink), 1);
    check("over.score", int'(bus.score_bcd), 'h99);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("over.ignore_state", int'(bus.state), 4);
    check("over.ignore_lives", int'(bus.lives), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("restart.state", int'(bus.state), 1);
    check("restart.lives", int'(bus.lives), 3);
    check("restart.score", int'(bus.score_bcd), 0);
    check("restart.brst", int'(bus.ball_reset), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("restart.brst_once", int'(bus.ball_reset), 0);

    // Button held through reset must not start a game.
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("held.idle", int'(bus.state), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("held.start", int'(bus.state), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("held.brst_once", int'(bus.ball_reset), 0);

    // Reset in the middle of the MISS hold.
    ticks(SERVE_F);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ticks(20);
    check("mid.state", int'(bus.state), 3);
    check("mid.blink", int'(bus.blink), 1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst.state",  int'(bus.state), 0);
    check("rst.run",    int'(bus.ball_run), 0);
    check("rst.brst",   int'(bus.ball_reset), 0);
    check("rst.paddle", int'(bus.paddle_en), 0);
    check("rst.speed",  int'(bus.speed), 0);
    check("rst.score",  int'(bus.score_bcd), 0);
    check("rst.lives",  int'(bus.lives), 3);
    check("rst.blink",  int'(bus.blink), 0);

    // Random play against the model.
    r_start = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 29) == 0) r_start = ~r_start;
      step($urandom_range(0, 999) == 0,
           $urandom_range(0, 2) == 0,
           r_start,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 59) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
